pincheck_seq: RTL and testbench

Sequencer for the pin/clock self-test block. It drives that block's `run` input and waits out a settle gap after each release. It then samples the 16-bit status word (already synchronised to `clk_i`), compares it against a required mask, retries a configurable number of times and latches a pass/fail result for the NIOS-side register file. It sits in the `clk_i` (system/CPU) domain between the firmware control registers and the self-test block.

---
 rtl/pincheck_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_pincheck_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pincheck_seq.sv
// pincheck_seq: sequencer for the pin/clock self-test block.
//
// Drives the self-test block's run enable, waits a settle gap before each
// attempt, holds RUN for a timeout window, then samples the synchronised
// status word against STATUS_MASK. A failed attempt is retried up to
// MAX_RETRIES extra times. The final pass/fail result is latched for the
// NIOS-side register file.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   start_i        one-cycle start strobe (ignored while busy)
//   abort_i        one-cycle abort strobe (wins over a same-cycle start)
//   status_i[15:0] self-test status word, already in the clk_i domain
//   run_o          run enable to the self-test block
//   busy_o         sequence active (GAP/RUN/EVAL)
//   done_o         one-cycle pulse when a result is latched
//   result_valid_o latched result is valid
//   pass_o         latched pass flag
//   status_o[15:0] status word captured at evaluation
//   fail_mask_o    STATUS_MASK bits that read 0 (all mask bits on abort)
//   attempts_o     RUN phases started in the current or last sequence
//
// Build option:
//   PINCHECK_SEQ_EARLY_EXIT_EN  leave RUN once the masked status has read
//                               all-ones for two consecutive RUN cycles.
//
// All outputs are registered; they are computed from the next state so
// they line up with the state the sequencer is in during each cycle.

module pincheck_seq #(
  parameter int          GAP_CYCLES     = 8,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          MAX_RETRIES    = 2,
  parameter logic [15:0] STATUS_MASK    = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] status_i,
  output logic        run_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        result_valid_o,
  output logic        pass_o,
  output logic [15:0] status_o,
  output logic [15:0] fail_mask_o,
  output logic [2:0]  attempts_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_RUN,
    S_EVAL,
    S_DONE
  } state_t;

  // Counters count down to zero, so they are loaded with length-1.
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        run_q, run_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        result_valid_q, result_valid_d;
  logic        pass_q, pass_d;
  logic [15:0] status_q, status_d;
  logic [15:0] fail_mask_q, fail_mask_d;
  logic [2:0]  attempts_q, attempts_d;
  logic [15:0] eval_fail;

`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
  // Remembers whether the previous RUN cycle already matched the mask.
  logic match_q, match_d;
  logic status_match;
  assign status_match = ((status_i & STATUS_MASK) == STATUS_MASK);
`endif

  assign eval_fail = STATUS_MASK & ~status_i;

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    pass_d         = pass_q;
    status_d       = status_q;
    fail_mask_d    = fail_mask_q;
    attempts_d     = attempts_q;
`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
    match_d        = match_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // A simultaneous abort cancels the start request.
        if (start_i && !abort_i) begin
          state_d        = S_GAP;
          gap_cnt_d      = GAP_LOAD;
          result_valid_d = 1'b0;
          pass_d         = 1'b0;
          attempts_d     = 3'd0;
          status_d       = 16'h0000;
          fail_mask_d    = 16'h0000;
        end
      end

      S_GAP: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else if (gap_cnt_q == 8'd0) begin
          state_d   = S_RUN;
          tmo_cnt_d = TMO_LOAD;
          if (attempts_q != 3'd7) begin
            attempts_d = attempts_q + 3'd1;
          end
`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
          match_d = 1'b0;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      S_RUN: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else if (tmo_cnt_q == 16'd0) begin
          state_d = S_EVAL;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 16'd1;
`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
          match_d = status_match;
          if (status_match && match_q) begin
            state_d = S_EVAL;
          end
`endif
        end
      end

      S_EVAL: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else begin
          status_d    = status_i;
          fail_mask_d = eval_fail;
          pass_d      = (eval_fail == 16'h0000);
          if ((eval_fail != 16'h0000) && (attempts_q <= RETRY_LIM)) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            result_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort from any active state: forced fail with every mask bit flagged,
    // captured status left untouched.
    if (abort_i && (state_q == S_GAP || state_q == S_RUN || state_q == S_EVAL)) begin
      done_d         = 1'b1;
      result_valid_d = 1'b1;
      pass_d         = 1'b0;
      fail_mask_d    = STATUS_MASK;
    end

    run_d  = (state_d == S_RUN) || (state_d == S_EVAL);
    busy_d = (state_d == S_GAP) || (state_d == S_RUN) || (state_d == S_EVAL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      gap_cnt_q      <= 8'd0;
      tmo_cnt_q      <= 16'd0;
      run_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      status_q       <= 16'h0000;
      fail_mask_q    <= 16'h0000;
      attempts_q     <= 3'd0;
`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
      match_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      run_q          <= run_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      pass_q         <= pass_d;
      status_q       <= status_d;
      fail_mask_q    <= fail_mask_d;
      attempts_q     <= attempts_d;
`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
      match_q        <= match_d;
`endif
    end
  end

  assign run_o          = run_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign result_valid_o = result_valid_q;
  assign pass_o         = pass_q;
  assign status_o       = status_q;
  assign fail_mask_o    = fail_mask_q;
  assign attempts_o     = attempts_q;

endmodule

// File: tb/tb_pincheck_seq.sv
// Testbench for pincheck_seq. Two instances: one with STATUS_MASK=16'hFFFF,
// one with STATUS_MASK=16'h07FF, both G=8, T=64, MAX_RETRIES=2.
// Expected results are queued at each start; per-instance monitors pop and
// compare on every done_o pulse.

module tb_pincheck_seq;

`ifdef PINCHECK_SEQ_EARLY_EXIT_EN
  localparam int PASS_LAT = 12;
`else
  localparam int PASS_LAT = 74;
`endif
  localparam int FAIL3_LAT = 220;

  typedef struct {
    int          s;
    int          lat;
    logic        pass;
    logic [15:0] fm;
    logic [2:0]  att;
    logic [15:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [15:0] status1 = 16'h0000;
  logic        run1, busy1, done1, rv1, pass1;
  logic [15:0] st1, fm1;
  logic [2:0]  att1;

  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [15:0] status2 = 16'h0000;
  logic        run2, busy2, done2, rv2, pass2;
  logic [15:0] st2, fm2;
  logic [2:0]  att2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pincheck_seq #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(64), .MAX_RETRIES(2),
                 .STATUS_MASK(16'hFFFF)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort1),
    .status_i(status1), .run_o(run1), .busy_o(busy1), .done_o(done1),
    .result_valid_o(rv1), .pass_o(pass1), .status_o(st1),
    .fail_mask_o(fm1), .attempts_o(att1));

  pincheck_seq #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(64), .MAX_RETRIES(2),
                 .STATUS_MASK(16'h07FF)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2),
    .status_i(status2), .run_o(run2), .busy_o(busy2), .done_o(done2),
    .result_valid_o(rv2), .pass_o(pass2), .status_o(st2),
    .fail_mask_o(fm2), .attempts_o(att2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for instance 1
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_done: got done_o=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("d1_latency", 32'(cyc - e1.s), 32'(e1.lat));
        chk("d1_pass", 32'(pass1), 32'(e1.pass));
        chk("d1_fail_mask", 32'(fm1), 32'(e1.fm));
        chk("d1_attempts", 32'(att1), 32'(e1.att));
        chk("d1_status", 32'(st1), 32'(e1.st));
        chk("d1_done_flags", {29'd0, run1, busy1, rv1}, 32'd1);
      end
    end
  end

  // Monitor for instance 2
  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d2_unexpected_done: got done_o=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("d2_latency", 32'(cyc - e2.s), 32'(e2.lat));
        chk("d2_pass", 32'(pass2), 32'(e2.pass));
        chk("d2_fail_mask", 32'(fm2), 32'(e2.fm));
        chk("d2_attempts", 32'(att2), 32'(e2.att));
        chk("d2_status", 32'(st2), 32'(e2.st));
        chk("d2_done_flags", {29'd0, run2, busy2, rv2}, 32'd1);
      end
    end
  end

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse start on instance 1 in the current cycle; returns the start cycle.
  task automatic go1(input logic [15:0] st, input int lat, input logic p,
                     input logic [15:0] fm, input logic [2:0] att,
                     input logic [15:0] exp_st, output int s);
    exp_t e;
    status1 = st;
    start1  = 1'b1;
    s       = cyc;
    e.s = s; e.lat = lat; e.pass = p; e.fm = fm; e.att = att; e.st = exp_st;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic go2(input logic [15:0] st, input int lat, input logic p,
                     input logic [15:0] fm, input logic [2:0] att,
                     input logic [15:0] exp_st, output int s);
    exp_t e;
    status2 = st;
    start2  = 1'b1;
    s       = cyc;
    e.s = s; e.lat = lat; e.pass = p; e.fm = fm; e.att = att; e.st = exp_st;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("reset_outputs1", {run1, busy1, done1, rv1, pass1, st1, fm1, att1}, 32'd0);
    chk("reset_outputs2", {run2, busy2, done2, rv2, pass2, st2, fm2, att2}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Start and abort in the same idle cycle: no sequence starts.
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("start_abort_idle_busy", 32'(busy1), 32'd0);
    repeat (5) @(negedge clk);

    // All-ones status: single-attempt pass.
    go1(16'hFFFF, PASS_LAT, 1'b1, 16'h0000, 3'd1, 16'hFFFF, s);
    to_cycle(s + 8);
    chk("p1_run_before_gap_end", {30'd0, run1, busy1}, 32'd1);
    to_cycle(s + 9);
    chk("p1_run_rise", 32'(run1), 32'd1);
    drain("pass1");
    chk("p1_result_hold", {29'd0, rv1, pass1, done1}, 32'd6);

    // Bit 10 stuck low: three attempts, settle gaps between them.
    go1(16'hFBFF, FAIL3_LAT, 1'b0, 16'h0400, 3'd3, 16'hFBFF, s);
    to_cycle(s + 73);
    chk("f3_eval1_run", 32'(run1), 32'd1);
    to_cycle(s + 74);
    chk("f3_gap2_start", {30'd0, run1, busy1}, 32'd1);
    to_cycle(s + 81);
    chk("f3_gap2_end", 32'(run1), 32'd0);
    to_cycle(s + 82);
    chk("f3_run2_rise", {29'd0, run1, att1}, 32'h0A);
    drain("fail3");

    // Abort during RUN.
    go1(16'h0000, 21, 1'b0, 16'hFFFF, 3'd1, 16'h0000, s);
    to_cycle(s + 20);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    drain("abort");

    // Reset mid-sequence: outputs clear, no done pulse, fresh start works.
    go1(16'h0000, 0, 1'b0, 16'h0000, 3'd0, 16'h0000, s);
    to_cycle(s + 40);
    q1.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outputs", {run1, busy1, done1, rv1, pass1, st1, fm1, att1}, 32'd0);
    repeat (100) @(negedge clk);
    go1(16'hFFFF, PASS_LAT, 1'b1, 16'h0000, 3'd1, 16'hFFFF, s);
    drain("after_reset");

    // Narrow mask: exact match passes; start while busy is ignored.
    go2(16'h07FF, PASS_LAT, 1'b1, 16'h0000, 3'd1, 16'h07FF, s);
    to_cycle(s + 30);
    if (busy2) begin
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
    end
    drain("mask_pass");

    // Narrow mask: a low bit outside the mask still passes.
    go2(16'hF7FF, PASS_LAT, 1'b1, 16'h0000, 3'd1, 16'hF7FF, s);
    drain("mask_outside");

    // Narrow mask: a low bit inside the mask fails after all retries.
    go2(16'h03FF, FAIL3_LAT, 1'b0, 16'h0400, 3'd3, 16'h03FF, s);
    drain("mask_fail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
